iter_shift_unit: RTL
====================

Name: iter_shift_unit

Overview:
- Parametrised multi-cycle shift unit for the MIPS datapath; next generation of the single-cycle ALU shift path.
- Supports SLL, SRL, true arithmetic SRA and ROR on a WIDTH-bit operand.
- Resolves the shift amount STEP bits per clock through a log-stage shifter.
- Valid/ready handshake on both sides, so the controller can stall while it waits for the result.

Parameters:
- WIDTH, 32: operand/result width in bits; must be a power of two, minimum 8.
- STEP, 1: shift-amount bits consumed per cycle (1..SHAMT_W).
- SHAMT_W, $clog2(WIDTH): derived, shift-amount width; not overridden.
- N, ceil(SHAMT_W/STEP): derived, number of shift cycles.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request.
- i_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- i_data  in  WIDTH  operand to shift.
- i_shamt  in  SHAMT_W  shift amount; only these bits count, no modulo beyond SHAMT_W.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_result  out  WIDTH  shifted result.
- o_zero  out  1  o_result equals zero.

Behaviour:
- States: IDLE, SHIFT, DONE.
- Reset (reset=0, async): state=IDLE, step counter=0, data and shamt regs=0, o_ready=1, o_valid=0, o_result=0, o_zero=1.
- o_ready=1 only in IDLE. o_valid=1 only in DONE. Both are registered-state decodes, with no combinational path from inputs.
- IDLE:
  - Accept on the edge where i_valid & o_ready.
  - Latch i_op, i_data and i_shamt, clear the counter, go to SHIFT.
  - i_valid with no acceptance has no effect.
- SHIFT:
  - Each edge k (k=0..N-1) takes chunk = shamt[k*STEP +: STEP], with bits beyond SHAMT_W read as 0.
  - It shifts the data reg by chunk << (k*STEP) using the latched op.
  - The last step edge moves to DONE.
  - Latency is fixed: o_valid is first visible after N edges following the accept edge (5 for the defaults), independent of shamt.
  - Inputs are ignored during SHIFT.
- Op rules per step:
  - SLL zero-fills on the right.
  - SRL zero-fills on the left.
  - SRA fills with the operand MSB. The MSB is latched at accept; the sign replicates correctly across all steps.
  - ROR rotates right.
  - The composite of all steps equals a single shift of the latched operand by i_shamt.
- DONE:
  - o_result holds the data reg and is stable while o_valid & !i_ready.
  - o_zero = ~|o_result.
  - An edge with i_ready=1 returns to IDLE; o_result keeps its last value, o_valid=0.
- There is no back-to-back acceptance in DONE. Throughput is one op per N+2 cycles when i_ready is held high.
- shamt=0 returns i_data unchanged after the full latency.
- Reset asserted mid-SHIFT or mid-DONE aborts the operation immediately. No o_valid is produced for it.
- X on i_op/i_data while not accepting must not propagate into state.

Decomposition:
- Package shift_pkg:
  - Op encoding constants OP_SLL, OP_SRL, OP_SRA, OP_ROR.
  - State encodings S_IDLE, S_SHIFT, S_DONE.
- Sub-module shift_step: combinational; inputs data, op, sign, chunk, base index k; output shifted data. It is instantiated once and reused every cycle.
- FSM, counter and handshake stay in iter_shift_unit.

Test Plan:
- Defaults, SRA, i_data=0x80000000, i_shamt=4 → o_result=0xF8000000. o_valid first seen 5 edges after accept. o_zero=0.
- SRL same operands → 0x08000000. SLL 0x00000001 by 31 → 0x80000000. ROR 0x00000001 by 1 → 0x80000000. ROR 0x12345678 by 8 → 0x78123456.
- SLL i_data=0xFFFFFFFF, i_shamt=0 → 0xFFFFFFFF after 5 edges. SRL 0x00000001 by 1 → 0x00000000 with o_zero=1.
- Backpressure: hold i_ready=0 for 3 cycles in DONE. o_result stays stable, o_ready=0, and an i_valid pulse with a new op is not accepted. Raising i_ready → IDLE next edge, o_ready=1.
- Reset: assert reset=0 two cycles after accept (mid-SHIFT). Immediately o_valid=0, o_ready=1, o_result=0. After release, a new SLL 0x3 by 2 → 0x0000000C.
- Parameter sweep WIDTH=32, STEP=2 and WIDTH=16, STEP=4: latency 3 and 1 respectively. Random ops and shamts match a reference model, with SRA checked on negative operands.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift unit: operation codes and FSM states.
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// One stage of the iterative shifter: shifts data by chunk << (k*STEP) under the given op.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1,
    parameter int unsigned KW    = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       op_i,
    input  logic             sign_i,
    input  logic [STEP-1:0]  chunk_i,
    input  logic [KW-1:0]    k_i,
    output logic [WIDTH-1:0] data_o
);

    logic [31:0]      amt;
    logic [WIDTH-1:0] fill;

    always_comb begin
        amt    = 32'(chunk_i) << (32'(k_i) * STEP);
        // Upper amt bits set by the sign for SRA; amt is always below WIDTH.
        fill   = ~({WIDTH{1'b1}} >> amt);
        data_o = data_i;
        case (op_i)
            OP_SLL:  data_o = data_i << amt;
            OP_SRL:  data_o = data_i >> amt;
            OP_SRA:  data_o = (data_i >> amt) | (sign_i ? fill : '0);
            OP_ROR:  data_o = (data_i >> amt) | (data_i << (32'(WIDTH) - amt));
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle SLL/SRL/SRA/ROR unit resolving STEP shift-amount bits per clock,
// with valid/ready handshakes on request and result sides.
module iter_shift_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned STEP    = 1,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [1:0]         i_op,
    input  logic [WIDTH-1:0]   i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WIDTH-1:0]   o_result,
    output logic               o_zero
);

    localparam int unsigned N     = (SHAMT_W + STEP - 1) / STEP;
    localparam int unsigned PAD_W = N * STEP;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [PAD_W-1:0] shamt_q, shamt_d;
    logic [1:0]       op_q, op_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] step_out;

    // shamt_q is consumed from the bottom, so the current chunk is always its low bits.
    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (CNT_W)
    ) u_step (
        .data_i  (data_q),
        .op_i    (op_q),
        .sign_i  (sign_q),
        .chunk_i (shamt_q[STEP-1:0]),
        .k_i     (cnt_q),
        .data_o  (step_out)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        shamt_d  = shamt_q;
        op_d     = op_q;
        sign_d   = sign_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    op_d    = i_op;
                    data_d  = i_data;
                    sign_d  = i_data[WIDTH-1];
                    shamt_d = PAD_W'(i_shamt);
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                data_d  = step_out;
                shamt_d = shamt_q >> STEP;
                if (cnt_q == LAST) begin
                    result_d = step_out;
                    cnt_d    = '0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            shamt_q  <= '0;
            op_q     <= OP_SLL;
            sign_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            shamt_q  <= shamt_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            result_q <= result_d;
        end
    end

    assign o_ready  = (state_q == S_IDLE);
    assign o_valid  = (state_q == S_DONE);
    assign o_result = result_q;
    assign o_zero   = ~|result_q;

endmodule
